vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator and pixel output stage that replaces the fixed 640x480 controller. It produces horizontal/vertical counters, sync pulses with programmable polarity, a data-enable, and frame/line markers, all gated by a pixel-clock enable. A configurable pipeline delay keeps hsync, vsync and data-enable aligned with colour data returned by an upstream pixel source, such as a frame buffer or pattern generator. The block sits between the pixel source and the board's VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- COLOR_W, 3, colour bus width
- PIPE, 1, en-ticks from coordinate request to rgb_in valid (0..4)
- clk  in  1  system clock; the block uses one clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel tick; all state advances only on clk edges with en=1
- rgb_in  in  COLOR_W  colour for the pixel requested PIPE ticks earlier
- pix_x  out  HW=$clog2(H_TOTAL)  current horizontal count (request side)
- pix_y  out  VW=$clog2(V_TOTAL)  current vertical count (request side)
- req_active  out  1  pix_x<H_ACTIVE and pix_y<V_ACTIVE
- line_start  out  1  high while pix_x==0
- frame_start  out  1  high while pix_x==0 and pix_y==0
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- de  out  1  delayed data-enable
- rgb  out  COLOR_W  rgb_in when de is high; otherwise 0

## Operation
- H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is formed the same way. Region order is active, front porch, sync, back porch.
- Horizontal counter h: 0..H_TOTAL-1. On an en tick at H_TOTAL-1 it wraps to 0, and v increments.
- Vertical counter v: 0..V_TOTAL-1. It wraps to 0 on the same tick that h wraps at v==V_TOTAL-1.
- pix_x=h and pix_y=v come directly from the counter registers. req_active, line_start and frame_start are combinational decodes of those registers.
- Raw horizontal sync is asserted for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]. Raw vertical sync follows the same rule using the V parameters.
- Output level for hsync: HS_POL when asserted, ~HS_POL otherwise. vsync follows the same rule with VS_POL.
- Raw hsync, raw vsync and req_active pass through a PIPE-deep shift register clocked on en. This is followed by one output register stage, which also captures rgb_in.
- rgb is registered as de_next ? rgb_in : 0. rgb is never nonzero during blanking.
- When en=0, every register holds its value.

## Timing
- Reset values: h=0, v=0, all delay stages inactive, hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0. Immediately after reset, pix_x=0, pix_y=0, req_active=1, frame_start=1 and line_start=1.
- Reset has priority over en. Reset mid-frame restarts at (0,0) on the next edge and flushes the delay line. There is no partial-frame recovery.
- Latency: counter value (h,v) is presented at tick n. rgb_in for that pixel is sampled at the en edge of tick n+PIPE. hsync, vsync, de and rgb for (h,v) are visible after that edge, which is PIPE+1 en-ticks after pix_x changed.
- PIPE=0: rgb_in is sampled at the same edge that advances the counter.
- Frame length is exactly H_TOTAL*V_TOTAL en-ticks. Sync and de waveforms are invariant to en duty cycle, measured in ticks.
- Elaboration check: each porch and sync parameter must be ≥1, and PIPE must be ≤4.

## Structure
- Package vga_pkg holds default 640x480@60 timing constants, the polarity constants SYNC_ACTIVE_LOW/HIGH, and a constant function total(a,f,s,b).
- Sub-module vga_axis_counter provides a wrap counter with an inc input, a wrap output and a sync-region decode. It is instantiated once for h and once for v, with the v instance's inc driven by h wrap & en.
- Top level contains the delay shift register and the output register.

## Test plan
- Default parameters, en=1 constant → hsync is low for 96 ticks starting when the delayed h equals 656; the period is 800 ticks; frame_start repeats every 420000 ticks.
- Default parameters → vsync is low for exactly lines 490–491, i.e. 1600 ticks; de is high for 640 ticks on each of lines 0–479 and low on lines 480–524.
- PIPE=2, rgb_in driven as a function of pix_x delayed by 2 ticks (rgb_in = pix_x[2:0] two ticks late) → rgb equals x[2:0] on every active pixel, the first pixel of each line is 0, and rgb is 0 throughout blanking.
- en asserted every 2nd clk → waveforms are identical in tick units; counters hold on en=0 cycles.
- Assert rst at h=300, v=200 for one cycle → the next outputs show pix_x=0, pix_y=0, de=0, hsync=1, vsync=1; the first de appears after PIPE+1 ticks.
- H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1 → period is 14 ticks, hsync is high at h=10–11, there are 98 ticks per frame, and vsync is high for 14 ticks on line 5.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel tick.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int total(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source / VGA-pin bundle. There is no valid/ready: every transfer is qualified
// by en alone, and rgb_in must carry the colour for the pixel requested PIPE en-ticks earlier.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 3,
    parameter int HW      = 10,
    parameter int VW      = 10
);
    logic               en;
    logic [COLOR_W-1:0] rgb_in;
    logic [HW-1:0]      pix_x;
    logic [VW-1:0]      pix_y;
    logic               req_active;
    logic               line_start;
    logic               frame_start;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COLOR_W-1:0] rgb;

    modport master (
        input  en, rgb_in,
        output pix_x, pix_y, req_active, line_start, frame_start,
        output hsync, vsync, de, rgb
    );

    modport slave (
        output en, rgb_in,
        input  pix_x, pix_y, req_active, line_start, frame_start,
        input  hsync, vsync, de, rgb
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync region decodes.
// o_wrap flags the terminal count; the caller decides whether it is consumed.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int W      = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_sync,
    output logic         o_active
);
    localparam int TOTAL      = total(ACTIVE, FRONT, SYNC, BACK);
    localparam int SYNC_FIRST = ACTIVE + FRONT;
    localparam int SYNC_LAST  = ACTIVE + FRONT + SYNC - 1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_wrap   = (r_count == W'(TOTAL - 1));
    assign o_sync   = (r_count >= W'(SYNC_FIRST)) && (r_count <= W'(SYNC_LAST));
    assign o_active = (r_count < W'(ACTIVE));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: request-side counters plus a delay line that
// realigns sync/de with colour returned by the upstream pixel source.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic HS_POL   = SYNC_ACTIVE_LOW,
    parameter logic VS_POL   = SYNC_ACTIVE_LOW,
    parameter int   COLOR_W  = 3,
    parameter int   PIPE     = 1
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || V_FRONT < 1 || V_SYNC < 1 ||
        V_BACK < 1 || PIPE < 0 || PIPE > 4) begin : g_bad_cfg
        $error("vga_timing_gen: porch/sync widths must be >= 1 and PIPE in 0..4");
    end

    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_h_wrap, w_h_sync, w_h_active;
    logic          w_v_sync, w_v_active, w_unused_v_wrap;
    logic          w_hs_next, w_vs_next, w_de_next;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(HW)
    ) u_h_cnt (
        .clk(clk), .rst(rst), .i_inc(bus.en),
        .o_count(w_h), .o_wrap(w_h_wrap), .o_sync(w_h_sync), .o_active(w_h_active)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(VW)
    ) u_v_cnt (
        .clk(clk), .rst(rst), .i_inc(w_h_wrap & bus.en),
        .o_count(w_v), .o_wrap(w_unused_v_wrap), .o_sync(w_v_sync), .o_active(w_v_active)
    );

    assign bus.pix_x       = w_h;
    assign bus.pix_y       = w_v;
    assign bus.req_active  = w_h_active & w_v_active;
    assign bus.line_start  = (w_h == '0);
    assign bus.frame_start = (w_h == '0) && (w_v == '0);

    // Raw sync/active travel as active-high flags; polarity is applied at the output.
    if (PIPE == 0) begin : g_no_dly
        assign w_hs_next = w_h_sync;
        assign w_vs_next = w_v_sync;
        assign w_de_next = bus.req_active;
    end else begin : g_dly
        logic [PIPE-1:0] r_hs_dly, r_vs_dly, r_de_dly;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_hs_dly <= '0;
                r_vs_dly <= '0;
                r_de_dly <= '0;
            end else if (bus.en) begin
                r_hs_dly <= (r_hs_dly << 1) | PIPE'(w_h_sync);
                r_vs_dly <= (r_vs_dly << 1) | PIPE'(w_v_sync);
                r_de_dly <= (r_de_dly << 1) | PIPE'(bus.req_active);
            end
        end

        assign w_hs_next = r_hs_dly[PIPE-1];
        assign w_vs_next = r_vs_dly[PIPE-1];
        assign w_de_next = r_de_dly[PIPE-1];
    end

    logic               r_hsync, r_vsync, r_de;
    logic [COLOR_W-1:0] r_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else if (bus.en) begin
            r_hsync <= w_hs_next ? HS_POL : ~HS_POL;
            r_vsync <= w_vs_next ? VS_POL : ~VS_POL;
            r_de    <= w_de_next;
            r_rgb   <= w_de_next ? bus.rgb_in : '0;
        end
    end

    assign bus.hsync = r_hsync;
    assign bus.vsync = r_vsync;
    assign bus.de    = r_de;
    assign bus.rgb   = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a wide-line instance (PIPE=2, active-low) and a tiny
// instance (PIPE=0, active-high) checked every cycle against a tick-index model.
module tb_vga_timing_gen;

    localparam int HA_A = 640, HF_A = 16, HS_A = 96, HB_A = 48;
    localparam int VA_A = 4, VF_A = 2, VS_A = 2, VB_A = 3;
    localparam int HT_A = HA_A + HF_A + HS_A + HB_A;
    localparam int VT_A = VA_A + VF_A + VS_A + VB_A;
    localparam int PIPE_A = 2, POL_A = 0;

    localparam int HA_B = 8, HF_B = 2, HS_B = 2, HB_B = 2;
    localparam int VA_B = 4, VF_B = 1, VS_B = 1, VB_B = 1;
    localparam int HT_B = HA_B + HF_B + HS_B + HB_B;
    localparam int VT_B = VA_B + VF_B + VS_B + VB_B;
    localparam int PIPE_B = 0, POL_B = 1;

    logic clk;
    logic rst;
    logic chk_on;
    int   t;
    int   total_cnt;
    int   bad_cnt;

    vga_timing_gen_if #(.COLOR_W(3), .HW(10), .VW(4)) bus_a ();
    vga_timing_gen_if #(.COLOR_W(3), .HW(4),  .VW(3)) bus_b ();

    vga_timing_gen #(
        .H_ACTIVE(HA_A), .H_FRONT(HF_A), .H_SYNC(HS_A), .H_BACK(HB_A),
        .V_ACTIVE(VA_A), .V_FRONT(VF_A), .V_SYNC(VS_A), .V_BACK(VB_A),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(3), .PIPE(PIPE_A)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA_B), .H_FRONT(HF_B), .H_SYNC(HS_B), .H_BACK(HB_B),
        .V_ACTIVE(VA_B), .V_FRONT(VF_B), .V_SYNC(VS_B), .V_BACK(VB_B),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(3), .PIPE(PIPE_B)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        total_cnt++;
        if (act != exp_v) begin
            bad_cnt++;
            if (bad_cnt <= 30)
                $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp_v);
        end
    endtask

    function automatic int in_win(input int c, input int first, input int len);
        return (c >= first && c < first + len) ? 1 : 0;
    endfunction

    // Colour the pixel source returns for a flat pixel index.
    function automatic int color_a(input int idx);
        return (idx % HT_A) % 8;
    endfunction

    function automatic int color_b(input int idx);
        return ((idx % HT_B) + ((idx / HT_B) % VT_B)) % 8;
    endfunction

    // driver: one clk cycle with given en/rst, model index follows the edge
    task automatic cyc(input logic e, input logic r);
        bus_a.en     = e;
        bus_b.en     = e;
        rst          = r;
        bus_a.rgb_in = (t - PIPE_A >= 0) ? 3'(color_a(t - PIPE_A)) : 3'b101;
        bus_b.rgb_in = 3'(color_b(t - PIPE_B));
        @(posedge clk);
        if (r) t = 0;
        else if (e) t++;
        #1;
    endtask

    task automatic check_a();
        int x, y, p, px, py, e_de, e_hs, e_vs, e_rgb;
        x = t % HT_A;
        y = (t / HT_A) % VT_A;
        chk("a_pix_x", int'(bus_a.pix_x), x);
        chk("a_pix_y", int'(bus_a.pix_y), y);
        chk("a_req_active", int'(bus_a.req_active), (x < HA_A && y < VA_A) ? 1 : 0);
        chk("a_line_start", int'(bus_a.line_start), (x == 0) ? 1 : 0);
        chk("a_frame_start", int'(bus_a.frame_start), (x == 0 && y == 0) ? 1 : 0);
        p = t - (PIPE_A + 1);
        if (p < 0) begin
            e_de = 0; e_hs = 1 - POL_A; e_vs = 1 - POL_A; e_rgb = 0;
        end else begin
            px    = p % HT_A;
            py    = (p / HT_A) % VT_A;
            e_de  = (px < HA_A && py < VA_A) ? 1 : 0;
            e_hs  = in_win(px, HA_A + HF_A, HS_A) ? POL_A : 1 - POL_A;
            e_vs  = in_win(py, VA_A + VF_A, VS_A) ? POL_A : 1 - POL_A;
            e_rgb = e_de ? color_a(p) : 0;
        end
        chk("a_hsync", int'(bus_a.hsync), e_hs);
        chk("a_vsync", int'(bus_a.vsync), e_vs);
        chk("a_de", int'(bus_a.de), e_de);
        chk("a_rgb", int'(bus_a.rgb), e_rgb);
    endtask

    task automatic check_b();
        int x, y, p, px, py, e_de, e_hs, e_vs, e_rgb;
        x = t % HT_B;
        y = (t / HT_B) % VT_B;
        chk("b_pix_x", int'(bus_b.pix_x), x);
        chk("b_pix_y", int'(bus_b.pix_y), y);
        chk("b_req_active", int'(bus_b.req_active), (x < HA_B && y < VA_B) ? 1 : 0);
        chk("b_frame_start", int'(bus_b.frame_start), (x == 0 && y == 0) ? 1 : 0);
        p = t - (PIPE_B + 1);
        if (p < 0) begin
            e_de = 0; e_hs = 1 - POL_B; e_vs = 1 - POL_B; e_rgb = 0;
        end else begin
            px    = p % HT_B;
            py    = (p / HT_B) % VT_B;
            e_de  = (px < HA_B && py < VA_B) ? 1 : 0;
            e_hs  = in_win(px, HA_B + HF_B, HS_B) ? POL_B : 1 - POL_B;
            e_vs  = in_win(py, VA_B + VF_B, VS_B) ? POL_B : 1 - POL_B;
            e_rgb = e_de ? color_b(p) : 0;
        end
        chk("b_hsync", int'(bus_b.hsync), e_hs);
        chk("b_vsync", int'(bus_b.vsync), e_vs);
        chk("b_de", int'(bus_b.de), e_de);
        chk("b_rgb", int'(bus_b.rgb), e_rgb);
    endtask

    // hand-computed points that pin the model
    task automatic pins();
        if (t == 0) begin
            chk("pin_rst_pix_x", int'(bus_a.pix_x), 0);
            chk("pin_rst_pix_y", int'(bus_a.pix_y), 0);
            chk("pin_rst_req_active", int'(bus_a.req_active), 1);
            chk("pin_rst_line_start", int'(bus_a.line_start), 1);
            chk("pin_rst_frame_start", int'(bus_a.frame_start), 1);
            chk("pin_rst_hsync", int'(bus_a.hsync), 1);
            chk("pin_rst_vsync", int'(bus_a.vsync), 1);
            chk("pin_rst_de", int'(bus_a.de), 0);
            chk("pin_rst_rgb", int'(bus_a.rgb), 0);
        end
        if (t == 2)   chk("pin_a_de_early", int'(bus_a.de), 0);
        if (t == 3)   begin chk("pin_a_de_first", int'(bus_a.de), 1); chk("pin_a_rgb_x0", int'(bus_a.rgb), 0); end
        if (t == 4)   chk("pin_a_rgb_x1", int'(bus_a.rgb), 1);
        if (t == 642) begin chk("pin_a_de_x639", int'(bus_a.de), 1); chk("pin_a_rgb_x639", int'(bus_a.rgb), 7); end
        if (t == 643) begin chk("pin_a_de_x640", int'(bus_a.de), 0); chk("pin_a_rgb_x640", int'(bus_a.rgb), 0); end
        if (t == 658) chk("pin_a_hs_h655", int'(bus_a.hsync), 1);
        if (t == 659) chk("pin_a_hs_h656", int'(bus_a.hsync), 0);
        if (t == 754) chk("pin_a_hs_h751", int'(bus_a.hsync), 0);
        if (t == 755) chk("pin_a_hs_h752", int'(bus_a.hsync), 1);
        if (t == 10)  chk("pin_b_hs_h9", int'(bus_b.hsync), 0);
        if (t == 11)  chk("pin_b_hs_h10", int'(bus_b.hsync), 1);
        if (t == 12)  chk("pin_b_hs_h11", int'(bus_b.hsync), 1);
        if (t == 13)  chk("pin_b_hs_h12", int'(bus_b.hsync), 0);
        if (t == 14)  begin chk("pin_b_line_start", int'(bus_b.line_start), 1); chk("pin_b_fs_line1", int'(bus_b.frame_start), 0); end
        if (t == 70)  chk("pin_b_vs_before", int'(bus_b.vsync), 0);
        if (t == 71)  chk("pin_b_vs_first", int'(bus_b.vsync), 1);
        if (t == 84)  chk("pin_b_vs_last", int'(bus_b.vsync), 1);
        if (t == 85)  chk("pin_b_vs_after", int'(bus_b.vsync), 0);
        if (t == 98)  chk("pin_b_frame_wrap", int'(bus_b.frame_start), 1);
    endtask

    // scoreboard: compare away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check_a();
            check_b();
            pins();
        end
    end

    initial begin
        int guard;
        chk_on    = 1'b0;
        t         = 0;
        total_cnt = 0;
        bad_cnt   = 0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk_on = 1'b1;

        // continuous ticks across a full frame of A and many frames of B
        repeat (9000) cyc(1'b1, 1'b0);

        // en every second clk
        repeat (1000) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end

        // advance to h=300, v=2 of A, then reset while en is low
        guard = 0;
        while ((t % (HT_A * VT_A)) != 2 * HT_A + 300 && guard < 20000) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        chk("seek_h300_v2", t % (HT_A * VT_A), 2 * HT_A + 300);
        cyc(1'b0, 1'b1);

        // restart with en on one clk in three
        repeat (900) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        repeat (200) cyc(1'b1, 1'b0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
